// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: GPR file with NRD combinational read ports, per-register
// busy bits for WAW/RAW tracking and a writeback-to-read bypass.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   rd_addr/rd_data NRD read ports (combinational), port i at [i*AW] / [i*XLEN]
//   rd_busy         per-port pending-write flag after bypass
//   rsv_valid/addr  issue reservation request; rsv_ready accepts it
//   wb_valid/addr/data  writeback commit, frees the destination register
//   err_unrsv       registered pulse on a commit to a register that was not busy
//   dbg_regs        all registers flattened, reg k at [k*XLEN +: XLEN]
module regfile_scoreboard #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 rsv_ready,
    input  logic                 wb_valid,
    input  logic [AW-1:0]        wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 err_unrsv,
    output logic [NREG*XLEN-1:0] dbg_regs
);

    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            err_q;
    logic            err_d;

    // Zero-padded to the full address space so any address indexes safely;
    // slots at or above NREG read as never busy.
    logic [2**AW-1:0] busy_ext;

    logic [AW-1:0] ra;
    logic          wb_en;
    logic          rsv_acc;
    logic          rsv_hit;

    function automatic logic in_rng(input logic [AW-1:0] a);
        return 32'(a) < 32'(NREG);
    endfunction

    always_comb begin
        busy_ext = '0;
        busy_ext[NREG-1:0] = busy_q;
    end

    // Read ports: x0 and out-of-range addresses read as 0 / not busy;
    // a same-cycle commit bypasses the array and clears busy.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = rd_addr[i*AW +: AW];
            if (ra == '0 || !in_rng(ra)) begin
                rd_data[i*XLEN +: XLEN] = '0;
                rd_busy[i] = 1'b0;
            end else if (wb_valid && wb_addr == ra) begin
                rd_data[i*XLEN +: XLEN] = wb_data;
                rd_busy[i] = 1'b0;
            end else begin
                rd_data[i*XLEN +: XLEN] = rf_q[ra];
                rd_busy[i] = busy_q[ra];
            end
        end
    end

    // Ready never looks at rsv_valid so issue can probe it freely.
    assign rsv_hit   = wb_valid && wb_addr == rsv_addr;
    assign rsv_ready = rsv_addr == '0 || !busy_ext[rsv_addr] || rsv_hit;
    assign rsv_acc   = rsv_valid && rsv_ready
                       && rsv_addr != '0 && in_rng(rsv_addr);
    assign wb_en     = wb_valid && wb_addr != '0 && in_rng(wb_addr);

    always_comb begin
        rf_d   = rf_q;
        busy_d = busy_q;
        err_d  = 1'b0;
        if (wb_en) begin
            rf_d[wb_addr]   = wb_data;
            busy_d[wb_addr] = 1'b0;
            err_d           = !busy_q[wb_addr];
        end
        // Applied after the clear so a same-address reservation wins.
        if (rsv_acc) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                rf_q[k] <= '0;
            end
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign err_unrsv = err_q;

    always_comb begin
        dbg_regs = '0;
        for (int k = 0; k < NREG; k++) begin
            dbg_regs[k*XLEN +: XLEN] = rf_q[k];
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a default 32x32 instance plus an
// RV32E-sized instance with three read ports.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Instance A: XLEN=32, NREG=32, NRD=2
    logic [9:0]    a_rd_addr;
    logic [63:0]   a_rd_data;
    logic [1:0]    a_rd_busy;
    logic          a_rsv_valid;
    logic [4:0]    a_rsv_addr;
    logic          a_rsv_ready;
    logic          a_wb_valid;
    logic [4:0]    a_wb_addr;
    logic [31:0]   a_wb_data;
    logic          a_err;
    logic [1023:0] a_dbg;

    // Instance B: XLEN=32, NREG=16, NRD=3
    logic [11:0]   b_rd_addr;
    logic [95:0]   b_rd_data;
    logic [2:0]    b_rd_busy;
    logic          b_rsv_valid;
    logic [3:0]    b_rsv_addr;
    logic          b_rsv_ready;
    logic          b_wb_valid;
    logic [3:0]    b_wb_addr;
    logic [31:0]   b_wb_data;
    logic          b_err;
    logic [511:0]  b_dbg;

    regfile_scoreboard #(.XLEN(32), .NREG(32), .NRD(2)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (a_rd_addr),
        .rd_data   (a_rd_data),
        .rd_busy   (a_rd_busy),
        .rsv_valid (a_rsv_valid),
        .rsv_addr  (a_rsv_addr),
        .rsv_ready (a_rsv_ready),
        .wb_valid  (a_wb_valid),
        .wb_addr   (a_wb_addr),
        .wb_data   (a_wb_data),
        .err_unrsv (a_err),
        .dbg_regs  (a_dbg)
    );

    regfile_scoreboard #(.XLEN(32), .NREG(16), .NRD(3)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (b_rd_addr),
        .rd_data   (b_rd_data),
        .rd_busy   (b_rd_busy),
        .rsv_valid (b_rsv_valid),
        .rsv_addr  (b_rsv_addr),
        .rsv_ready (b_rsv_ready),
        .wb_valid  (b_wb_valid),
        .wb_addr   (b_wb_addr),
        .wb_data   (b_wb_data),
        .err_unrsv (b_err),
        .dbg_regs  (b_dbg)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_rsv_valid = 1'b0;
        a_rsv_addr  = '0;
        a_wb_valid  = 1'b0;
        a_wb_addr   = '0;
        a_wb_data   = '0;
        b_rsv_valid = 1'b0;
        b_rsv_addr  = '0;
        b_wb_valid  = 1'b0;
        b_wb_addr   = '0;
        b_wb_data   = '0;
    endtask

    initial begin
        rst       = 1'b1;
        a_rd_addr = '0;
        b_rd_addr = '0;
        idle();
        tick();
        rst = 1'b0;

        // 1. preload, then reset (with a colliding commit) clears everything
        a_wb_valid = 1'b1;
        a_wb_addr  = 5'd3;
        a_wb_data  = 32'h0000_AAAA;
        tick();
        idle();
        a_rsv_valid = 1'b1;
        a_rsv_addr  = 5'd4;
        b_wb_valid  = 1'b1;
        b_wb_addr   = 4'd2;
        b_wb_data   = 32'h1111_2222;
        tick();
        idle();
        a_rd_addr = {5'd3, 5'd4};
        #1;
        chk("preload_busy4", {62'd0, a_rd_busy}, 64'd1);
        chk("preload_rf3", {32'd0, a_rd_data[63:32]}, 64'h0000_AAAA);
        rst        = 1'b1;
        a_wb_valid = 1'b1;
        a_wb_addr  = 5'd3;
        a_wb_data  = 32'h0000_BBBB;
        tick();
        rst = 1'b0;
        idle();
        #1;
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("rst_a_x%0d", k), {32'd0, a_dbg[k*32 +: 32]}, 64'd0);
        end
        chk("rst_b_any", {63'd0, |b_dbg}, 64'd0);
        chk("rst_busy", {62'd0, a_rd_busy}, 64'd0);
        chk("rst_err", {63'd0, a_err}, 64'd0);

        // 2. reserve x5, then commit with bypass
        a_rd_addr   = {5'd0, 5'd5};
        a_rsv_valid = 1'b1;
        a_rsv_addr  = 5'd5;
        #1;
        chk("rsv5_ready", {63'd0, a_rsv_ready}, 64'd1);
        chk("rsv5_busy_before", {63'd0, a_rd_busy[0]}, 64'd0);
        tick();
        idle();
        #1;
        chk("rsv5_busy_after", {63'd0, a_rd_busy[0]}, 64'd1);
        a_wb_valid = 1'b1;
        a_wb_addr  = 5'd5;
        a_wb_data  = 32'hDEAD_BEEF;
        #1;
        chk("byp5_data", {32'd0, a_rd_data[31:0]}, 64'hDEAD_BEEF);
        chk("byp5_busy", {63'd0, a_rd_busy[0]}, 64'd0);
        tick();
        idle();
        #1;
        chk("rf5_data", {32'd0, a_rd_data[31:0]}, 64'hDEAD_BEEF);
        chk("rf5_busy", {63'd0, a_rd_busy[0]}, 64'd0);
        chk("rf5_dbg", {32'd0, a_dbg[5*32 +: 32]}, 64'hDEAD_BEEF);
        chk("rf5_err", {63'd0, a_err}, 64'd0);

        // 3. WAW stall, then reserve in the commit cycle (set wins)
        a_rsv_valid = 1'b1;
        a_rsv_addr  = 5'd5;
        tick();
        #1;
        chk("waw_ready", {63'd0, a_rsv_ready}, 64'd0);
        tick();
        #1;
        chk("waw_busy_held", {63'd0, a_rd_busy[0]}, 64'd1);
        chk("waw_ready_again", {63'd0, a_rsv_ready}, 64'd0);
        a_wb_valid = 1'b1;
        a_wb_addr  = 5'd5;
        a_wb_data  = 32'h0000_0077;
        #1;
        chk("waw_ready_wb", {63'd0, a_rsv_ready}, 64'd1);
        tick();
        idle();
        #1;
        chk("waw_rf5", {32'd0, a_rd_data[31:0]}, 64'h0000_0077);
        chk("waw_busy5", {63'd0, a_rd_busy[0]}, 64'd1);
        chk("waw_err", {63'd0, a_err}, 64'd0);
        a_wb_valid = 1'b1;
        a_wb_addr  = 5'd5;
        a_wb_data  = 32'h0000_0078;
        tick();
        idle();
        #1;
        chk("free5_busy", {63'd0, a_rd_busy[0]}, 64'd0);

        // 4. x0: commit discarded, reservation accepted as a no-op
        a_rd_addr   = {5'd0, 5'd0};
        a_wb_valid  = 1'b1;
        a_wb_addr   = 5'd0;
        a_wb_data   = 32'h0000_1234;
        a_rsv_valid = 1'b1;
        a_rsv_addr  = 5'd0;
        #1;
        chk("x0_ready", {63'd0, a_rsv_ready}, 64'd1);
        chk("x0_data", {32'd0, a_rd_data[63:32]}, 64'd0);
        chk("x0_busy", {62'd0, a_rd_busy}, 64'd0);
        tick();
        idle();
        #1;
        chk("x0_err", {63'd0, a_err}, 64'd0);
        chk("x0_dbg", {32'd0, a_dbg[31:0]}, 64'd0);
        chk("x0_busy_after", {62'd0, a_rd_busy}, 64'd0);

        // 5. commit to unreserved x7, with independent reservation of x9
        a_rd_addr   = {5'd9, 5'd7};
        a_wb_valid  = 1'b1;
        a_wb_addr   = 5'd7;
        a_wb_data   = 32'h0000_0055;
        a_rsv_valid = 1'b1;
        a_rsv_addr  = 5'd9;
        tick();
        idle();
        #1;
        chk("unrsv_err_hi", {63'd0, a_err}, 64'd1);
        chk("unrsv_rf7", {32'd0, a_rd_data[31:0]}, 64'h0000_0055);
        chk("indep_busy", {62'd0, a_rd_busy}, 64'd2);
        tick();
        #1;
        chk("unrsv_err_lo", {63'd0, a_err}, 64'd0);

        // 6. RV32E instance with three ports
        b_rd_addr  = {4'd3, 4'd3, 4'd3};
        b_wb_valid = 1'b1;
        b_wb_addr  = 4'd3;
        b_wb_data  = 32'h0000_00A5;
        #1;
        chk("b_byp_p0", {32'd0, b_rd_data[31:0]}, 64'h0000_00A5);
        chk("b_byp_p1", {32'd0, b_rd_data[63:32]}, 64'h0000_00A5);
        chk("b_byp_p2", {32'd0, b_rd_data[95:64]}, 64'h0000_00A5);
        chk("b_byp_busy", {61'd0, b_rd_busy}, 64'd0);
        tick();
        b_wb_addr = 4'd15;
        b_wb_data = 32'h0F0F_0F0F;
        tick();
        idle();
        b_rd_addr = {4'd3, 4'd0, 4'd15};
        #1;
        chk("b_rf15", {32'd0, b_rd_data[31:0]}, 64'h0F0F_0F0F);
        chk("b_x0", {32'd0, b_rd_data[63:32]}, 64'd0);
        chk("b_rf3", {32'd0, b_rd_data[95:64]}, 64'h0000_00A5);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
